// File: rtl/cnn_pkg.sv
// cnn_pkg: shared frame geometry, stream-buffer state encodings and checksum width.
package cnn_pkg;
  localparam int IMG_DIM = 28;
  localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
  localparam int PIX_W = 8;
  localparam int CSUM_W = 16;
  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/pixel_ram.sv
// pixel_ram: single-write, synchronous-read frame store; read register holds when not enabled.
module pixel_ram #(
  parameter int DEPTH = 784,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/image_stream_buffer.sv
// image_stream_buffer: loads a 28x28 byte frame, then replays it gap-free on each start edge.
// Optional IMG_CHECKSUM_EN builds a 16-bit modular byte sum of the loaded frame.
module image_stream_buffer #(
  parameter int IMG_PIXELS = 784,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              start,
  input  logic              reload,
  output logic              loaded,
  output logic              busy,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              frame_done,
  output logic [15:0]       checksum
);
  import cnn_pkg::*;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_PIXELS - 1);
  logic [1:0] state;
  logic [ADDR_W-1:0] wr_cnt, rd_cnt;
  logic start_d, start_posedge, wr_en, wr_last, rd_last;
  assign start_posedge = start & ~start_d;
  assign wr_ready = state == S_LOAD;
  assign loaded = state == S_READY || state == S_DONE;
  assign busy = state == S_STREAM;
  assign wr_en = wr_ready & wr_valid & ~reload;
  assign wr_last = wr_cnt == LAST;
  assign rd_last = rd_cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_LOAD;
      wr_cnt <= '0;
      rd_cnt <= '0;
      start_d <= 1'b0;
      pix_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      start_d <= start;
      pix_valid <= busy;
      frame_done <= state == S_DONE;
      case (state)
        S_LOAD:
          if (reload) wr_cnt <= '0;
          else if (wr_en) begin
            wr_cnt <= wr_last ? wr_cnt : wr_cnt + 1'b1;
            state <= wr_last ? S_READY : S_LOAD;
          end
        S_READY:
          if (reload) begin
            state <= S_LOAD;
            wr_cnt <= '0;
          end else if (start_posedge) begin
            state <= S_STREAM;
            rd_cnt <= '0;
          end
        S_STREAM: begin
          rd_cnt <= rd_last ? rd_cnt : rd_cnt + 1'b1;
          state <= rd_last ? S_DONE : S_STREAM;
        end
        default: begin
          state <= reload ? S_LOAD : S_READY;
          if (reload) wr_cnt <= '0;
        end
      endcase
    end
`ifdef IMG_CHECKSUM_EN
  // Cleared by any reload the FSM honours, i.e. outside streaming.
  always_ff @(posedge clk or posedge rst)
    if (rst) checksum <= '0;
    else if (reload && !busy) checksum <= '0;
    else if (wr_en) checksum <= checksum + CSUM_W'(wr_data);
`else
  assign checksum = '0;
`endif
  pixel_ram #(.DEPTH(IMG_PIXELS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_cnt),
    .wr_data(wr_data),
    .rd_en(busy),
    .rd_addr(rd_cnt),
    .rd_data(pix_data)
  );
endmodule

// File: tb/tb_image_stream_buffer.sv
// tb_image_stream_buffer: randomized load/stream scenarios checked against a frame-array model.
module tb_image_stream_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic start = 1'b0;
  logic reload = 1'b0;
  logic wr_ready, loaded, busy, pix_valid, frame_done;
  logic [7:0] pix_data;
  logic [15:0] checksum;
  int checks = 0;
  int errors = 0;
  logic [7:0] img [784];
  logic [15:0] model_sum;

  image_stream_buffer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .reload(reload), .loaded(loaded), .busy(busy), .pix_valid(pix_valid),
    .pix_data(pix_data), .frame_done(frame_done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_csum();
`ifdef IMG_CHECKSUM_EN
    return model_sum;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_ready, loaded, busy, pix_valid, frame_done, pix_data, checksum} !== {5'b10000, 8'h00, 16'h0000}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b ld=%b busy=%b pv=%b fd=%b pd=%h cs=%h, need 1 0 0 0 0 00 0000",
               wr_ready, loaded, busy, pix_valid, frame_done, pix_data, checksum);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // kind 0: i mod 256 with valid held; 1: random bytes with random gaps; 2: all 0xFF
  task automatic load_frame(input int kind, input bit start_mid);
    int n = 0;
    int cyc = 0;
    bit bad_rdy = 0;
    model_sum = 16'h0000;
    while (n < 784 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (wr_ready !== 1'b1) bad_rdy = 1;
      wr_valid = (kind == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data = (kind == 0) ? 8'(n) : (kind == 2) ? 8'hFF : 8'($urandom);
      if (start_mid && n == 100) start = 1'b1;
      if (wr_valid) begin
        img[n] = wr_data;
        model_sum = model_sum + 16'(wr_data);
        n++;
      end
    end
    checks++;
    if (n != 784 || bad_rdy) begin
      errors++;
      $display("FAIL load_accept: accepted %0d ready_dropped=%0d, need 784 and 0", n, bad_rdy);
    end
    @(negedge clk);
    wr_data = 8'hAA;
    checks++;
    if ({wr_ready, loaded, busy} !== 3'b010) begin
      errors++;
      $display("FAIL load_end: got rdy=%b ld=%b busy=%b, need 0 1 0", wr_ready, loaded, busy);
    end
    checks++;
    if (checksum !== exp_csum()) begin
      errors++;
      $display("FAIL checksum: got %h, need %h", checksum, exp_csum());
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic run_stream(input int reload_at, input int rst_at);
    int bad = 0;
    int first = -1;
    logic [7:0] got_d = 8'h00;
    logic got_v = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, pix_valid, loaded} !== 3'b100) begin
      errors++;
      $display("FAIL stream_entry: got busy=%b pv=%b ld=%b, need 1 0 0", busy, pix_valid, loaded);
    end
    for (int k = 0; k < 784; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({pix_valid, busy, loaded, wr_ready, pix_data} !== {4'b0001, 8'h00}) begin
          errors++;
          $display("FAIL rst_mid_stream: got pv=%b busy=%b ld=%b rdy=%b pd=%h, need 0 0 0 1 00",
                   pix_valid, busy, loaded, wr_ready, pix_data);
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (pix_valid !== 1'b1 || pix_data !== img[k]) begin
        if (bad == 0) begin
          first = k;
          got_v = pix_valid;
          got_d = pix_data;
        end
        bad++;
      end
      reload = (k == reload_at);
    end
    reload = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stream_pixels: %0d bad, first at %0d got pv=%b pd=%h, need pv=1 pd=%h",
               bad, first, got_v, got_d, img[first]);
    end
    @(negedge clk);
    checks++;
    if ({pix_valid, frame_done, busy, loaded} !== 4'b0101) begin
      errors++;
      $display("FAIL frame_done: got pv=%b fd=%b busy=%b ld=%b, need 0 1 0 1", pix_valid, frame_done, busy, loaded);
    end
    @(negedge clk);
    checks++;
    if ({pix_valid, frame_done, loaded, pix_data} !== {3'b001, img[783]}) begin
      errors++;
      $display("FAIL after_frame: got pv=%b fd=%b ld=%b pd=%h, need 0 0 1 %h",
               pix_valid, frame_done, loaded, pix_data, img[783]);
    end
  endtask

  task automatic test_start_held();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || pix_valid || frame_done) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL start_held: got replay activity=1, need 0");
    end
    run_stream(-1, -1);
  endtask

  task automatic pulse_reload(input bit with_start);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = with_start;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    start = 1'b0;
    checks++;
    if ({wr_ready, loaded, busy, checksum} !== {3'b100, 16'h0000}) begin
      errors++;
      $display("FAIL reload_ready: got rdy=%b ld=%b busy=%b cs=%h, need 1 0 0 0000", wr_ready, loaded, busy, checksum);
    end
  endtask

  task automatic test_ignored();
    pulse_reload(1'b0);
    load_frame(1, 1'b1);
    run_stream(200, -1);
    run_stream(-1, -1);
  endtask

  task automatic test_rst_mid_stream();
    run_stream(-1, 400);
    load_frame(1, 1'b0);
    run_stream(-1, -1);
  endtask

  task automatic test_reload_ff();
    pulse_reload(1'b1);
    load_frame(2, 1'b0);
    run_stream(-1, -1);
  endtask

  initial begin
    test_reset();
    load_frame(0, 1'b0);
    run_stream(-1, -1);
    test_start_held();
    test_ignored();
    test_rst_mid_stream();
    test_reload_ff();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
